// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte requesters.
// Optional watchdog abort in WAIT is enabled by defining UART_TX_ARB_WDOG_EN.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DBITS       = 8,
    parameter int WDOG_CYCLES = 65536
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*DBITS-1:0]   i_data,
    output logic [NREQ-1:0]         o_ack,
    output logic [NREQ-1:0]         o_done,
    output logic                    o_tx_start,
    output logic [DBITS-1:0]        o_tx_data,
    input  logic                    i_tx_done,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int            PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e              state_q;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       owner_q;
    logic [DBITS-1:0]    tx_data_q;
    logic [NREQ-1:0]     ack_q;
    logic [NREQ-1:0]     done_q;
    logic                start_q;
    logic                busy_q;
    logic                err_q;

    logic [DBITS-1:0]    data_arr [NREQ];
    logic                gnt_found;
    logic [PW-1:0]       gnt_idx;
    logic [PW-1:0]       ptr_d;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            data_arr[k] = i_data[k*DBITS +: DBITS];
        end
    end

    // Search upward from the pointer; the wrap is an explicit compare so any NREQ works.
    always_comb begin
        logic [PW-1:0] idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && i_req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
        ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end

`ifdef UART_TX_ARB_WDOG_EN
    localparam int            WW      = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);
    logic [WW-1:0]            wdog_q;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES != 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            tx_data_q <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
            wdog_q    <= '0;
`endif
        end else begin
            ack_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        tx_data_q <= data_arr[gnt_idx];
                        owner_q   <= gnt_idx;
                        ack_q     <= ONE << gnt_idx;
                        start_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        ptr_q     <= ptr_d;
                        state_q   <= S_WAIT;
`ifdef UART_TX_ARB_WDOG_EN
                        wdog_q    <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        done_q  <= ONE << owner_q;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
`ifdef UART_TX_ARB_WDOG_EN
                    else if (wdog_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wdog_q  <= wdog_q + 1'b1;
                    end
`endif
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ack      = ack_q;
    assign o_done     = done_q;
    assign o_tx_start = start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a rotation model predicts each grant,
// a negedge monitor pops and compares every ack/start and done the DUT presents.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DBITS = 8;
    localparam int WDOG  = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       i_req;
    logic [NREQ*DBITS-1:0] i_data;
    logic                  i_tx_done;
    logic [NREQ-1:0]       o_ack;
    logic [NREQ-1:0]       o_done;
    logic                  o_tx_start;
    logic [DBITS-1:0]      o_tx_data;
    logic                  o_busy;
    logic                  o_err;

    uart_tx_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .WDOG_CYCLES(WDOG)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_done     (o_done),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_grant[$];
    exp_t exp_done[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   model_ptr   = 0;
    bit   wd_expect   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Rotation rule: first pending requester at or after the model pointer, modulo NREQ.
    function automatic int predict(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(model_ptr + i) % NREQ]) return (model_ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic grant(output int k);
        int   t;
        exp_t e;
        k = predict(i_req);
        if (k < 0) begin
            flag("no_pending_request");
            k = 0;
            return;
        end
        e.idx  = k;
        e.data = i_data[k*DBITS +: DBITS];
        exp_grant.push_back(e);
        exp_done.push_back(e);
        model_ptr = (k + 1) % NREQ;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (o_ack == '0 && t < 8);
        if (o_ack == '0) flag("ack_timeout");
    endtask

    task automatic finish_frame(input int delay);
        repeat (delay) @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
    endtask

    task automatic random_burst();
        int k;
        int n;
        int j;
        for (int q = 0; q < NREQ; q++) i_data[q*DBITS +: DBITS] = 8'($urandom);
        i_req = 4'($urandom_range(1, 15));
        n = 0;
        while (i_req != '0 && n < 6) begin
            grant(k);
            n++;
            i_req[k] = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                i_data[k*DBITS +: DBITS] = 8'($urandom);
                i_req[k] = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) begin
                j = $urandom_range(0, NREQ - 1);
                i_req[j] = 1'b0;
            end
            finish_frame($urandom_range(0, 12));
        end
        i_req = '0;
        if ($urandom_range(0, 3) == 0) finish_frame(1);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (o_ack != '0 || o_tx_start) begin
                if (exp_grant.size() == 0) begin
                    flag("unexpected_grant");
                end else begin
                    e = exp_grant.pop_front();
                    check("ack_onehot", 32'(o_ack), 32'(1) << e.idx);
                    check("tx_start", 32'(o_tx_start), 32'd1);
                    check("tx_data", 32'(o_tx_data), 32'(e.data));
                    check("busy_at_grant", 32'(o_busy), 32'd1);
                end
            end
            if (o_done != '0) begin
                if (exp_done.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    e = exp_done.pop_front();
                    check("done_onehot", 32'(o_done), 32'(1) << e.idx);
                    check("tx_data_held", 32'(o_tx_data), 32'(e.data));
                    check("busy_at_done", 32'(o_busy), 32'd0);
                end
            end
            if (o_err && !wd_expect) flag("unexpected_err");
        end
    end

    initial begin
        int k;
        int t;
        rst_n     = 1'b0;
        i_req     = '0;
        i_data    = '0;
        i_tx_done = 1'b0;
        #12;
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_start", 32'(o_tx_start), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 2.
        i_data[2*DBITS +: DBITS] = 8'hA5;
        i_req = 4'b0100;
        grant(k);
        i_req[k] = 1'b0;
        finish_frame(3);

        // Pointer now at 3: 0011 wraps to 0 then 1, then 1000 gives 3.
        i_data[0*DBITS +: DBITS] = 8'h31;
        i_data[1*DBITS +: DBITS] = 8'h32;
        i_req = 4'b0011;
        grant(k);
        i_req[k] = 1'b0;
        finish_frame(2);
        grant(k);
        i_req[k] = 1'b0;
        finish_frame(2);
        i_data[3*DBITS +: DBITS] = 8'h44;
        i_req = 4'b1000;
        grant(k);
        i_req[k] = 1'b0;
        finish_frame(2);

        // Fairness with all four held high.
        i_data = 32'h1312_1110;
        i_req  = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            grant(k);
            if (n == 4) i_req = '0;
            finish_frame(19);
        end

        // Spurious done in IDLE.
        finish_frame(2);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("spurious_no_done", 32'(o_done), 32'd0);
            check("spurious_idle", 32'(o_busy), 32'd0);
        end

        // No done: watchdog aborts when compiled in, otherwise the frame waits forever.
        i_data[2*DBITS +: DBITS] = 8'h5C;
        i_req = 4'b0100;
        grant(k);
        i_req = '0;
`ifdef UART_TX_ARB_WDOG_EN
        void'(exp_done.pop_back());
        wd_expect = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_err && t < 40);
        check("wdog_latency", 32'(t), 32'(WDOG));
        @(negedge clk);
        wd_expect = 1'b0;
        check("wdog_idle", 32'(o_busy), 32'd0);
`else
        repeat (40) @(negedge clk);
        check("hang_busy", 32'(o_busy), 32'd1);
        check("hang_err", 32'(o_err), 32'd0);
        finish_frame(0);
`endif

        // Reset mid-frame.
        i_data[0*DBITS +: DBITS] = 8'h5A;
        i_req = 4'b0001;
        grant(k);
        i_req = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(o_ack), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        check("midrst_start", 32'(o_tx_start), 32'd0);
        check("midrst_tx_data", 32'(o_tx_data), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_err", 32'(o_err), 32'd0);
        exp_grant.delete();
        exp_done.delete();
        model_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        finish_frame(1);
        check("stale_done", 32'(o_done), 32'd0);
        i_data[3*DBITS +: DBITS] = 8'h66;
        i_data[0*DBITS +: DBITS] = 8'h67;
        i_req = 4'b1001;
        grant(k);
        i_req[k] = 1'b0;
        finish_frame(1);
        i_req = '0;
        @(negedge clk);
        i_data[1*DBITS +: DBITS] = 8'h77;
        i_req = 4'b0010;
        grant(k);
        i_req = '0;
        finish_frame(4);

        // Randomized traffic.
        repeat (40) random_burst();

        repeat (5) @(negedge clk);
        check("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
